// File: rtl/dff_bank_seq_ctrl.sv
// -----------------------------------------------------------------------------
// dff_bank_seq_ctrl
//
// Command sequencer for a WIDTH-bit register bank made of D flops with an
// asynchronous preset and a synchronous clear. It accepts LOAD / CLEAR /
// PRESET / READ commands on a valid/ready port. It drives the bank control
// pins, reads the bank back after each command, reports the value it read,
// and flags any difference from the expected value. This block is the only
// driver of the bank control pins.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active-low
//   cmd_valid  in   command present, held until accepted
//   cmd_ready  out  controller idle; a transfer is cmd_valid & cmd_ready at an edge
//   cmd_op     in   00 LOAD, 01 CLEAR, 10 PRESET, 11 READ
//   cmd_data   in   LOAD value (ignored for the other ops)
//   bank_prst  out  bank asynchronous preset strobe (active-high)
//   bank_rst   out  bank synchronous clear strobe (active-high)
//   bank_ld    out  bank load enable
//   bank_d     out  bank data input (zero whenever bank_ld is low)
//   bank_q     in   bank outputs
//   busy       out  high in every state except IDLE
//   done       out  one-cycle completion pulse
//   err        out  read-back mismatch, meaningful only while done is high
//   rd_data    out  bank_q captured in CHECK; held until the next CHECK
// -----------------------------------------------------------------------------
module dff_bank_seq_ctrl #(
  parameter int WIDTH     = 8,
  parameter int PULSE_CYC = 2,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             bank_prst,
  output logic             bank_rst,
  output logic             bank_ld,
  output logic [WIDTH-1:0] bank_d,
  input  logic [WIDTH-1:0] bank_q,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] rd_data
);

  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_CLEAR  = 2'b01;
  localparam logic [1:0] OP_PRESET = 2'b10;
  localparam logic [1:0] OP_READ   = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_PULSE = CNT_W'(PULSE_CYC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       op_q, op_n;
  logic [WIDTH-1:0] exp_q, exp_n;

  logic             cmd_ready_n, bank_prst_n, bank_rst_n, bank_ld_n;
  logic             busy_n, done_n, err_n;
  logic [WIDTH-1:0] bank_d_n, rd_data_n;

  // Every output is a flop. The comb block computes the value each output
  // takes at the next edge, so the outputs change only on clock edges (or on
  // reset).
  always_comb begin
    // NOTE: every signal gets a default before the case statement, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_n     = state;
    cnt_n       = cnt;
    op_n        = op_q;
    exp_n       = exp_q;
    cmd_ready_n = 1'b0;
    bank_prst_n = 1'b0;
    bank_rst_n  = 1'b0;
    bank_ld_n   = 1'b0;
    bank_d_n    = '0;
    done_n      = 1'b0;
    err_n       = 1'b0;
    rd_data_n   = rd_data;

    unique case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_n  = cmd_op;
          cnt_n = CNT_ONE;
          state_n = DRIVE;
          unique case (cmd_op)
            OP_LOAD: begin
              exp_n     = cmd_data;
              bank_ld_n = 1'b1;
              bank_d_n  = cmd_data;
            end
            OP_CLEAR: begin
              exp_n      = '0;
              bank_rst_n = 1'b1;
            end
            OP_PRESET: begin
              exp_n       = '1;
              bank_prst_n = 1'b1;
              cnt_n       = CNT_PULSE;
            end
            default: begin
              // READ has no expected value and goes straight to CHECK.
              exp_n   = '0;
              state_n = CHECK;
            end
          endcase
        end else begin
          cmd_ready_n = 1'b1;
        end
      end

      DRIVE: begin
        // The strobe stays up while the counter runs. It drops on the same
        // edge that leaves DRIVE.
        if (cnt == CNT_ONE) begin
          state_n = CHECK;
        end else begin
          cnt_n       = cnt - CNT_ONE;
          bank_prst_n = bank_prst;
          bank_rst_n  = bank_rst;
          bank_ld_n   = bank_ld;
          bank_d_n    = bank_d;
        end
      end

      CHECK: begin
        rd_data_n = bank_q;
        err_n     = (op_q != OP_READ) && (bank_q != exp_q);
        done_n    = 1'b1;
        state_n   = RESP;
      end

      default: begin  // RESP
        cmd_ready_n = 1'b1;
        state_n     = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  // Every flop sees the pre-edge values, whatever the statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op_q      <= OP_LOAD;
      exp_q     <= '0;
      cmd_ready <= 1'b0;
      bank_prst <= 1'b0;
      bank_rst  <= 1'b0;
      bank_ld   <= 1'b0;
      bank_d    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rd_data   <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      op_q      <= op_n;
      exp_q     <= exp_n;
      cmd_ready <= cmd_ready_n;
      bank_prst <= bank_prst_n;
      bank_rst  <= bank_rst_n;
      bank_ld   <= bank_ld_n;
      bank_d    <= bank_d_n;
      busy      <= busy_n;
      done      <= done_n;
      err       <= err_n;
      rd_data   <= rd_data_n;
    end
  end

endmodule

// File: tb/tb_dff_bank_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dff_bank_seq_ctrl
//
// Directed bench for dff_bank_seq_ctrl. The DUT drives a flop-bank model that
// has an async preset and a sync clear, and one bit of the model can be forced
// to read back as 1. Each stimulus task checks its expected values inline.
// Outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_dff_bank_seq_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [WIDTH-1:0] cmd_data = '0;
  logic             bank_prst, bank_rst, bank_ld;
  logic [WIDTH-1:0] bank_d, bank_q, bank_reg;
  logic             busy, done, err;
  logic [WIDTH-1:0] rd_data;
  logic             stuck = 1'b0;

  int checks = 0;
  int errors = 0;
  int overlap = 0;

  always #5 clk = ~clk;

  dff_bank_seq_ctrl #(.WIDTH(WIDTH), .PULSE_CYC(2), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data),
    .bank_prst(bank_prst), .bank_rst(bank_rst), .bank_ld(bank_ld),
    .bank_d(bank_d), .bank_q(bank_q),
    .busy(busy), .done(done), .err(err), .rd_data(rd_data)
  );

  // Bank model: async preset, sync clear, load enable.
  always_ff @(posedge clk or posedge bank_prst) begin
    if (bank_prst)     bank_reg <= '1;
    else if (bank_rst) bank_reg <= '0;
    else if (bank_ld)  bank_reg <= bank_d;
  end
  assign bank_q = bank_reg | {{(WIDTH-1){1'b0}}, stuck};

  // Strobe exclusivity, and bank_d quiet while bank_ld is low.
  always @(negedge clk) begin
    if ((int'(bank_prst) + int'(bank_rst) + int'(bank_ld)) > 1) overlap++;
    if (!bank_ld && bank_d !== '0) overlap++;
  end

  // Present a command and return 1 unit after its acceptance edge E0. The
  // inputs are then scrambled to confirm that they are ignored while busy.
  task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] data);
    int n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
    while (!cmd_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL send_timeout: cmd_ready never rose (waited %0d cycles)", n);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 2'b11; cmd_data = 8'h5A;
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    step(2);
    checks++;
    if ({cmd_ready, busy, done, err, bank_prst, bank_rst, bank_ld} !== 7'b0 ||
        bank_d !== 8'h00 || rd_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b busy=%b done=%b err=%b prst=%b rst=%b ld=%b d=%h rd=%h, required all 0",
               cmd_ready, busy, done, err, bank_prst, bank_rst, bank_ld, bank_d, rd_data);
    end
    rst = 1'b1;
    step(1);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%b busy=%b, required 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_load;
    send(2'b00, 8'hA5);
    checks++;
    if (bank_ld !== 1'b1 || bank_d !== 8'hA5 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_strobe: ld=%b d=%h busy=%b ready=%b, required 1 a5 1 0",
               bank_ld, bank_d, busy, cmd_ready);
    end
    step(1);
    checks++;
    if (bank_ld !== 1'b0 || bank_d !== 8'h00 || done !== 1'b0) begin
      errors++;
      $display("FAIL load_e1: ld=%b d=%h done=%b, required 0 00 0", bank_ld, bank_d, done);
    end
    step(1);
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || rd_data !== 8'hA5) begin
      errors++;
      $display("FAIL load_done: done=%b err=%b rd=%h, required 1 0 a5", done, err, rd_data);
    end
    step(1);
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL load_resp_exit: done=%b ready=%b busy=%b, required 0 1 0", done, cmd_ready, busy);
    end
  endtask

  task automatic test_preset;
    send(2'b10, 8'h00);
    checks++;
    if (bank_prst !== 1'b1 || bank_q !== 8'hFF) begin
      errors++;
      $display("FAIL preset_e0: prst=%b q=%h, required 1 ff", bank_prst, bank_q);
    end
    step(1);
    checks++;
    if (bank_prst !== 1'b1 || bank_q !== 8'hFF || done !== 1'b0) begin
      errors++;
      $display("FAIL preset_e1: prst=%b q=%h done=%b, required 1 ff 0", bank_prst, bank_q, done);
    end
    step(1);
    checks++;
    if (bank_prst !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL preset_e2: prst=%b done=%b, required 0 0", bank_prst, done);
    end
    step(1);
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || rd_data !== 8'hFF) begin
      errors++;
      $display("FAIL preset_done: done=%b err=%b rd=%h, required 1 0 ff", done, err, rd_data);
    end
  endtask

  task automatic test_clear_read;
    send(2'b01, 8'hC3);
    checks++;
    if (bank_rst !== 1'b1 || bank_ld !== 1'b0 || bank_prst !== 1'b0) begin
      errors++;
      $display("FAIL clear_strobe: rst=%b ld=%b prst=%b, required 1 0 0", bank_rst, bank_ld, bank_prst);
    end
    step(1);
    checks++;
    if (bank_rst !== 1'b0 || bank_q !== 8'h00 || done !== 1'b0) begin
      errors++;
      $display("FAIL clear_e1: rst=%b q=%h done=%b, required 0 00 0", bank_rst, bank_q, done);
    end
    step(1);
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || rd_data !== 8'h00) begin
      errors++;
      $display("FAIL clear_done: done=%b err=%b rd=%h, required 1 0 00", done, err, rd_data);
    end
    send(2'b11, 8'hFF);
    checks++;
    if ({bank_prst, bank_rst, bank_ld} !== 3'b000 || done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL read_e0: strobes=%b done=%b busy=%b, required 000 0 1",
               {bank_prst, bank_rst, bank_ld}, done, busy);
    end
    step(1);
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || rd_data !== 8'h00) begin
      errors++;
      $display("FAIL read_done: done=%b err=%b rd=%h, required 1 0 00", done, err, rd_data);
    end
  endtask

  task automatic test_mismatch;
    stuck = 1'b1;
    send(2'b00, 8'h00);
    step(2);
    checks++;
    if (done !== 1'b1 || err !== 1'b1 || rd_data !== 8'h01) begin
      errors++;
      $display("FAIL mismatch_done: done=%b err=%b rd=%h, required 1 1 01", done, err, rd_data);
    end
    step(1);
    checks++;
    if (done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL mismatch_clear: done=%b err=%b, required 0 0", done, err);
    end
    send(2'b10, 8'h00);
    step(3);
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || rd_data !== 8'hFF) begin
      errors++;
      $display("FAIL mismatch_next: done=%b err=%b rd=%h, required 1 0 ff", done, err, rd_data);
    end
    stuck = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [1:0]       ops  [3] = '{2'b00, 2'b01, 2'b10};
    logic [WIDTH-1:0] dats [3] = '{8'h3C, 8'h77, 8'h00};
    logic [WIDTH-1:0] exps [3] = '{8'h3C, 8'h00, 8'hFF};
    int n_acc = 0;
    int n_done = 0;
    logic acc;
    overlap = 0;
    cmd_valid = 1'b1; cmd_op = ops[0]; cmd_data = dats[0];
    for (int cyc = 0; cyc < 40; cyc++) begin
      acc = cmd_valid && cmd_ready;
      step(1);
      if (acc) begin
        n_acc++;
        if (n_acc < 3) begin
          cmd_op = ops[n_acc]; cmd_data = dats[n_acc];
        end else begin
          cmd_valid = 1'b0;
        end
      end
      if (done === 1'b1) begin
        checks++;
        if (n_done > 2 || rd_data !== exps[n_done > 2 ? 2 : n_done] || err !== 1'b0) begin
          errors++;
          $display("FAIL b2b_done%0d: rd=%h err=%b, required %h 0",
                   n_done, rd_data, err, exps[n_done > 2 ? 2 : n_done]);
        end
        n_done++;
      end
    end
    checks++;
    if (n_acc !== 3 || n_done !== 3) begin
      errors++;
      $display("FAIL b2b_counts: accepted=%0d dones=%0d, required 3 3", n_acc, n_done);
    end
    checks++;
    if (overlap !== 0) begin
      errors++;
      $display("FAIL b2b_overlap: violations=%0d, required 0", overlap);
    end
  endtask

  task automatic test_reset_abort;
    int n_done = 0;
    send(2'b00, 8'h12);
    step(3);
    send(2'b10, 8'h00);
    checks++;
    if (bank_prst !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre: prst=%b busy=%b, required 1 1", bank_prst, busy);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bank_prst !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b0 || done !== 1'b0 ||
        rd_data !== 8'h00) begin
      errors++;
      $display("FAIL abort_async: prst=%b busy=%b ready=%b done=%b rd=%h, required 0 0 0 0 00",
               bank_prst, busy, cmd_ready, done, rd_data);
    end
    #3 rst = 1'b1;
    step(1);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || bank_q !== 8'hFF) begin
      errors++;
      $display("FAIL abort_release: ready=%b busy=%b q=%h, required 1 0 ff", cmd_ready, busy, bank_q);
    end
    for (int i = 0; i < 6; i++) begin
      if (done === 1'b1) n_done++;
      step(1);
    end
    checks++;
    if (n_done !== 0) begin
      errors++;
      $display("FAIL abort_no_done: dones=%0d, required 0", n_done);
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset;
    test_load;
    test_preset;
    test_clear_read;
    test_mismatch;
    test_back_to_back;
    test_reset_abort;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
